// File: rtl/display_pkg.sv
// Shared display encodings and helpers for the status stage and pixel_gen.
package display_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_UP   = 2'b01,
        ST_DOWN = 2'b10,
        ST_DOOR = 2'b11
    } sim_state_t;

    localparam int unsigned BLINK_FRAMES_DEFAULT = 15;
    localparam int unsigned MIN_DWELL_DEFAULT    = 4;

    typedef struct packed {
        logic [7:0] req_floors;
        logic [2:0] current_floor;
        logic       moving;
        logic       dir_up;
        logic       door_open;
    } snapshot_t;

    // A door that is open outranks any motion indication.
    function automatic sim_state_t target_state(input snapshot_t s);
        if (s.door_open)              return ST_DOOR;
        else if (s.moving && s.dir_up) return ST_UP;
        else if (s.moving)             return ST_DOWN;
        else                           return ST_IDLE;
    endfunction

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        return 8'b1 << idx;
    endfunction

endpackage

// File: rtl/vsync_edge_detect.sv
// Synchronises the asynchronous active-low vsync and emits a one-cycle
// pulse on its falling edge.
module vsync_edge_detect (
    input  logic clk,
    input  logic reset,
    input  logic vsync_in,
    output logic frame_tick
);

    logic s1_q, s2_q, s3_q;

    // NOTE: non-blocking assignments keep s1->s2->s3 a true shift chain;
    // blocking ones would collapse it into a single flop.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_q <= 1'b1;
            s2_q <= 1'b1;
            s3_q <= 1'b1;
        end else begin
            s1_q <= vsync_in;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    assign frame_tick = s3_q & ~s2_q;

endmodule

// File: rtl/display_status_sync.sv
// Frame-synchronised status stage: snapshots elevator status once per frame
// and produces the state and floor bitmap consumed by the VGA controller.
module display_status_sync
    import display_pkg::*;
#(
    parameter int unsigned BLINK_FRAMES = BLINK_FRAMES_DEFAULT,
    parameter int unsigned MIN_DWELL    = MIN_DWELL_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       vsync_in,
    input  logic [7:0] req_floors,
    input  logic [2:0] current_floor,
    input  logic       moving,
    input  logic       dir_up,
    input  logic       door_open,
    output logic [7:0] destination,
    output logic [1:0] sim_state,
    output logic       frame_tick
);

    localparam logic [5:0] BLINK_LAST = 6'(BLINK_FRAMES - 1);
    localparam logic [3:0] DWELL_LAST = 4'(MIN_DWELL - 1);

    sim_state_t state_q, state_d, target;
    logic [3:0] dwell_q, dwell_d;
    logic [5:0] blink_cnt_q, blink_cnt_d;
    logic       blink_on_q, blink_on_d;
    logic [7:0] dest_q, dest_d;
    logic       marker;
    snapshot_t  snap;

    vsync_edge_detect u_edge (
        .clk        (clk),
        .reset      (reset),
        .vsync_in   (vsync_in),
        .frame_tick (frame_tick)
    );

    // Live inputs are only looked at on a tick; the registered outputs
    // below are the shadow copy that holds for the whole frame.
    assign snap = '{req_floors:    req_floors,
                    current_floor: current_floor,
                    moving:        moving,
                    dir_up:        dir_up,
                    door_open:     door_open};

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        dwell_d     = dwell_q;
        blink_cnt_d = blink_cnt_q;
        blink_on_d  = blink_on_q;
        dest_d      = dest_q;
        target      = target_state(snap);
        marker      = 1'b0;

        if (frame_tick) begin
            if (target != state_q && dwell_q >= DWELL_LAST) begin
                state_d = target;
                dwell_d = '0;
            end else if (dwell_q != 4'hF) begin
                dwell_d = dwell_q + 4'd1;
            end

            if (blink_cnt_q == BLINK_LAST) begin
                blink_cnt_d = '0;
                blink_on_d  = ~blink_on_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 6'd1;
            end

            // Composition follows the state and blink phase entering this frame.
            unique case (state_d)
                ST_UP, ST_DOWN: marker = blink_on_d;
                ST_DOOR:        marker = 1'b1;
                default:        marker = 1'b0;
            endcase
            dest_d = snap.req_floors | (marker ? onehot8(snap.current_floor) : 8'h00);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            dwell_q     <= '0;
            blink_cnt_q <= '0;
            blink_on_q  <= 1'b0;
            dest_q      <= '0;
        end else begin
            state_q     <= state_d;
            dwell_q     <= dwell_d;
            blink_cnt_q <= blink_cnt_d;
            blink_on_q  <= blink_on_d;
            dest_q      <= dest_d;
        end
    end

    assign destination = dest_q;
    assign sim_state   = state_q;

endmodule

// File: tb/tb_display_status_sync.sv
// Randomised self-checking bench for display_status_sync against a
// frame-level behavioural model.
module tb_display_status_sync;

    localparam int BLINK_FRAMES = 2;
    localparam int MIN_DWELL    = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       vsync_in;
    logic [7:0] req_floors;
    logic [2:0] current_floor;
    logic       moving, dir_up, door_open;
    logic [7:0] destination;
    logic [1:0] sim_state;
    logic       frame_tick;

    int checks = 0;
    int errors = 0;

    // Frame-level model state.
    int         m_ticks;
    int         m_since_change;
    logic [1:0] m_state;
    logic [7:0] m_dest;
    logic       m_pending;
    logic [1:0] m_next_state;
    logic [7:0] m_next_dest;

    display_status_sync #(
        .BLINK_FRAMES (BLINK_FRAMES),
        .MIN_DWELL    (MIN_DWELL)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .vsync_in      (vsync_in),
        .req_floors    (req_floors),
        .current_floor (current_floor),
        .moving        (moving),
        .dir_up        (dir_up),
        .door_open     (door_open),
        .destination   (destination),
        .sim_state     (sim_state),
        .frame_tick    (frame_tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, actual, expected, $time);
        end
    endtask

    task automatic model_reset();
        m_ticks        = 0;
        m_since_change = 0;
        m_state        = 2'b00;
        m_dest         = 8'h00;
        m_pending      = 1'b0;
    endtask

    // One frame start: decide the state for the coming frame from the inputs
    // seen right now, and the bitmap it should display.
    task automatic model_tick();
        logic [1:0] tgt;
        logic       blink;
        logic       show;
        if (door_open)            tgt = 2'b11;
        else if (moving && dir_up) tgt = 2'b01;
        else if (moving)           tgt = 2'b10;
        else                       tgt = 2'b00;
        m_next_state = m_state;
        if (tgt != m_state && m_since_change >= MIN_DWELL - 1) begin
            m_next_state   = tgt;
            m_since_change = 0;
        end else begin
            m_since_change++;
        end
        m_ticks++;
        blink = ((m_ticks / BLINK_FRAMES) % 2) == 1;
        show  = (m_next_state == 2'b11) || ((m_next_state == 2'b01 || m_next_state == 2'b10) && blink);
        m_next_dest = req_floors | (show ? (8'h01 << current_floor) : 8'h00);
        m_pending   = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        if (m_pending) begin
            m_state   = m_next_state;
            m_dest    = m_next_dest;
            m_pending = 1'b0;
        end
        check({tag, ".state"}, 32'(sim_state), 32'(m_state));
        check({tag, ".dest"}, 32'(destination), 32'(m_dest));
    endtask

    task automatic set_inputs(input logic [7:0] req, input logic [2:0] fl,
                              input logic mv, input logic up, input logic dr);
        req_floors    = req;
        current_floor = fl;
        moving        = mv;
        dir_up        = up;
        door_open     = dr;
    endtask

    // Entered and left on a negedge. Drives vsync low for low_n clocks then
    // high for high_n clocks, sampling on every negedge. Inputs are scrambled
    // once the snapshot has been taken to prove later changes are ignored.
    task automatic run_frame(input string tag, input int low_n, input int high_n, input logic glitch);
        int ticks = 0;
        int pos   = -1;
        vsync_in = 1'b0;
        for (int i = 0; i < low_n + high_n; i++) begin
            if (i == low_n) vsync_in = 1'b1;
            @(negedge clk);
            check_outputs(tag);
            if (pos >= 0 && i == pos + 1)
                set_inputs(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            if (frame_tick) begin
                ticks++;
                if (pos < 0) pos = i;
                model_tick();
            end
        end
        if (glitch) begin
            check({tag, ".glitch_ticks_le1"}, 32'(ticks <= 1), 32'd1);
        end else begin
            check({tag, ".ticks"}, 32'(ticks), 32'd1);
            check({tag, ".tick_pos"}, 32'(pos), 32'd1);
        end
    endtask

    initial begin
        model_reset();
        reset    = 1'b1;
        vsync_in = 1'b1;
        set_inputs(8'h00, 3'd0, 1'b0, 1'b0, 1'b0);

        // Reset with idle vsync, then release.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("rst.tick", 32'(frame_tick), 32'd0);
            check_outputs("rst");
        end
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("idle.tick", 32'(frame_tick), 32'd0);
            check_outputs("idle");
        end

        // Snapshot timing.
        set_inputs(8'h24, 3'd0, 1'b0, 1'b0, 1'b0);
        run_frame("snap", 4, 6, 1'b0);
        check("snap.hold", 32'(destination), 32'h24);
        set_inputs(8'h24, 3'd0, 1'b0, 1'b0, 1'b0);
        run_frame("snap2", 3, 5, 1'b0);

        // Dwell enforcement: UP, then door requested.
        set_inputs(8'h00, 3'd2, 1'b1, 1'b1, 1'b0);
        run_frame("dwell_up", 2, 4, 1'b0);
        for (int f = 0; f < 4; f++) begin
            set_inputs(8'h00, 3'd2, 1'b1, 1'b1, 1'b1);
            run_frame("dwell_door", 2, 4, 1'b0);
        end

        // Blink in UP, bit-already-set case, then steady in DOOR.
        for (int f = 0; f < 8; f++) begin
            set_inputs(8'h00, 3'd5, 1'b1, 1'b1, 1'b0);
            run_frame("blink_up", 2, 3, 1'b0);
        end
        for (int f = 0; f < 4; f++) begin
            set_inputs(8'h20, 3'd5, 1'b1, 1'b1, 1'b0);
            run_frame("blink_set", 2, 3, 1'b0);
        end
        for (int f = 0; f < 6; f++) begin
            set_inputs(8'h00, 3'd5, 1'b0, 1'b0, 1'b1);
            run_frame("door_steady", 3, 3, 1'b0);
        end

        // Reset coincident with a tick.
        set_inputs(8'h81, 3'd3, 1'b1, 1'b0, 1'b0);
        vsync_in = 1'b0;
        @(negedge clk);
        check_outputs("rot.e0");
        @(negedge clk);
        check("rot.tick", 32'(frame_tick), 32'd1);
        check_outputs("rot.e1");
        reset    = 1'b1;
        vsync_in = 1'b1;
        model_reset();
        @(negedge clk);
        check("rot.tick_after", 32'(frame_tick), 32'd0);
        check_outputs("rot.rst");
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_outputs("rot.idle");
        end
        for (int f = 0; f < 6; f++) begin
            set_inputs(8'h81, 3'd3, 1'b1, 1'b0, 1'b0);
            run_frame("rot.after", 2, 4, 1'b0);
        end

        // Glitch between valid frames, then long-low vsync.
        set_inputs(8'h10, 3'd1, 1'b0, 1'b0, 1'b0);
        run_frame("pre_glitch", 3, 4, 1'b0);
        set_inputs(8'h10, 3'd1, 1'b0, 1'b0, 1'b0);
        run_frame("glitch", 1, 5, 1'b1);
        set_inputs(8'h10, 3'd1, 1'b0, 1'b0, 1'b0);
        run_frame("post_glitch", 3, 4, 1'b0);
        set_inputs(8'h42, 3'd6, 1'b1, 1'b0, 1'b0);
        run_frame("long_low", 100, 5, 1'b0);

        // Randomised frames.
        for (int f = 0; f < 60; f++) begin
            set_inputs(8'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                       ($urandom_range(0, 3) == 0));
            run_frame("rand", int'($urandom_range(2, 6)), int'($urandom_range(3, 8)), 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
